// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI frame validator and peripheral config register bank
// Optional feature macro: SPI_REG_CTRL_ERR_CNT_EN enables the saturating reject counter.
module spi_reg_ctrl #(
  parameter int         ERR_W    = 8,
  parameter logic [7:0] DUTY_RST = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic             rx_read_write,
  input  logic [6:0]       rx_addr,
  input  logic [7:0]       rx_data,
  output logic [7:0]       en_reg_out_7_0,
  output logic [7:0]       en_reg_out_15_8,
  output logic [7:0]       en_reg_pwm_7_0,
  output logic [7:0]       en_reg_pwm_15_8,
  output logic [7:0]       pwm_duty_cycle,
  output logic             busy,
  output logic             wr_strobe,
  output logic [6:0]       wr_addr,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;

  state_t     state_q, state_d;
  logic       valid_q;
  logic       txn_rw_q;
  logic [6:0] txn_addr_q;
  logic [7:0] txn_data_q;
  logic [7:0] out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
  logic       wr_strobe_q;
  logic [6:0] wr_addr_q;
  logic       rise;
  logic       txn_ok;
  logic       latch_en;
  logic       commit;

  // valid_q resets high so a level already present at reset release is not a new frame
  assign rise   = rx_valid & ~valid_q;
  assign txn_ok = txn_rw_q && (txn_addr_q <= 7'h04);

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          latch_en = 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK:   state_d = txn_ok ? WRITE : IDLE;
      WRITE: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= 1'b1;
      txn_rw_q    <= 1'b0;
      txn_addr_q  <= 7'h00;
      txn_data_q  <= 8'h00;
      out_lo_q    <= 8'h00;
      out_hi_q    <= 8'h00;
      pwm_lo_q    <= 8'h00;
      pwm_hi_q    <= 8'h00;
      duty_q      <= DUTY_RST;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 7'h00;
    end else begin
      state_q     <= state_d;
      valid_q     <= rx_valid;
      wr_strobe_q <= commit;
      if (latch_en) begin
        txn_rw_q   <= rx_read_write;
        txn_addr_q <= rx_addr;
        txn_data_q <= rx_data;
      end
      if (commit) begin
        wr_addr_q <= txn_addr_q;
        case (txn_addr_q)
          7'h00:   out_lo_q <= txn_data_q;
          7'h01:   out_hi_q <= txn_data_q;
          7'h02:   pwm_lo_q <= txn_data_q;
          7'h03:   pwm_hi_q <= txn_data_q;
          7'h04:   duty_q   <= txn_data_q;
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign busy            = (state_q != IDLE);
  assign wr_strobe       = wr_strobe_q;
  assign wr_addr         = wr_addr_q;

`ifdef SPI_REG_CTRL_ERR_CNT_EN
  logic             reject;
  logic [ERR_W-1:0] err_q;

  // an invalid frame leaving CHECK and an overrun edge in the same cycle count once
  assign reject = ((state_q == CHECK) && !txn_ok) || (rise && (state_q != IDLE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (reject && (err_q != '1)) begin
      err_q <= err_q + ERR_W'(1);
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule
